// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU execute-stage units.
//   state_e        : iterative multiplier FSM states (2-bit encoding)
//   ENC_*          : raw state encodings backing state_e
//   clog2()        : ceil(log2(value)), used to size iteration counters
package alu_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_SIGN = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    SIGN = ENC_SIGN,
    DONE = ENC_DONE
  } state_e;

  // Smallest r with 2**r >= value; a counter reaching WIDTH needs clog2(WIDTH+1) bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_cond_negate.sv
// cond_negate: combinational two's-complement negate gated by an enable.
//   en : 1 -> y = -d (mod 2^N), 0 -> y = d
//   d  : N-bit input value
//   y  : N-bit result
module cond_negate #(
  parameter int N = 8
) (
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] y
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  assign y = en ? (~d + ONE) : d;

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, signed or unsigned per operation.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   ena        : clock enable; all state, outputs and start acceptance hold when low
//   start      : request, accepted in IDLE/DONE on an ena cycle
//   sgn        : 1 = two's-complement operands, 0 = unsigned (latched at start)
//   a, b       : multiplier / multiplicand operands (latched at start)
//   p          : 2*WIDTH-bit product, updated only at completion
//   busy       : high from start-accept edge to completion edge
//   dne        : high from completion edge until the next accepted start
// Operands are reduced to magnitudes at accept time, the magnitude product is
// accumulated one multiplier bit per ena cycle, and the sign is applied once.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               dne
);

  localparam int              CW       = clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam bit              EE_ON    = (EARLY_EXIT != 0);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 dne_q, dne_d;

  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [2*WIDTH-1:0]   p_signed_s;
  logic                 run_exit_s;

  // Most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  cond_negate #(.N(WIDTH)) u_neg_a (
    .en (sgn & a[WIDTH-1]),
    .d  (a),
    .y  (a_mag_s)
  );

  cond_negate #(.N(WIDTH)) u_neg_b (
    .en (sgn & b[WIDTH-1]),
    .d  (b),
    .y  (b_mag_s)
  );

  // A zero magnitude negates to zero, so "negative zero" yields p = 0.
  cond_negate #(.N(2*WIDTH)) u_neg_p (
    .en (neg_q),
    .d  (acc_q),
    .y  (p_signed_s)
  );

  assign run_exit_s = (cnt_q == CNT_MAX) || (EE_ON && (mplr_q == {WIDTH{1'b0}}));

  // Next-state and datapath update; everything holds while ena is low.
  always_comb begin
    state_d = state_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    busy_d  = busy_q;
    dne_d   = dne_q;
    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            mplr_d  = a_mag_s;
            mcand_d = {{WIDTH{1'b0}}, b_mag_s};
            acc_d   = {(2*WIDTH){1'b0}};
            cnt_d   = {CW{1'b0}};
            neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy_d  = 1'b1;
            dne_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          // The exit check consumes its own cycle with no arithmetic.
          if (run_exit_s) begin
            state_d = SIGN;
          end else begin
            if (mplr_q[0]) begin
              acc_d = acc_q + mcand_q;
            end else begin
              acc_d = acc_q;
            end
            mplr_d  = mplr_q >> 1;
            mcand_d = mcand_q << 1;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        SIGN: begin
          state_d = DONE;
          p_d     = p_signed_s;
          busy_d  = 1'b0;
          dne_d   = 1'b1;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          dne_d   = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mplr_q  <= {WIDTH{1'b0}};
      mcand_q <= {(2*WIDTH){1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      neg_q   <= 1'b0;
      p_q     <= {(2*WIDTH){1'b0}};
      busy_q  <= 1'b0;
      dne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      dne_q   <= dne_d;
    end
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign dne  = dne_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] p;
  logic        busy;
  logic        dne;

  logic        ena8;
  logic        start8;
  logic        sgn8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] p8;
  logic        busy8;
  logic        dne8;

  int checks;
  int errors;

  logic [63:0] sb_p[$];
  int          sb_lat[$];
  logic [63:0] last_p;
  int          lat_cnt;
  logic        dne_prev;

  seq_multiplier #(.WIDTH(32), .EARLY_EXIT(1)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .sgn(sgn),
    .a(a), .b(b), .p(p), .busy(busy), .dne(dne)
  );

  seq_multiplier #(.WIDTH(8), .EARLY_EXIT(0)) u_dut8 (
    .clk(clk), .rst(rst), .ena(ena8), .start(start8), .sgn(sgn8),
    .a(a8), .b(b8), .p(p8), .busy(busy8), .dne(dne8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication of the operands as numbers.
  function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end else begin
      return {32'd0, x} * {32'd0, y};
    end
  endfunction

  // Reference latency: bit length of |a| plus two.
  function automatic int ref_lat(input bit s, input logic [31:0] x);
    longint m;
    int k;
    logic signed [63:0] sx;
    sx = $signed(x);
    if (s && sx < 0) m = -sx;
    else m = longint'({32'd0, x});
    k = 0;
    while (m > 0) begin
      m = m / 2;
      k++;
    end
    return k + 2;
  endfunction

  // Count ena edges spent busy; an accepting edge restarts the count.
  always @(posedge clk) begin
    if (!rst && ena && !busy && start) lat_cnt <= 0;
    else if (!rst && ena && busy) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= lat_cnt;
  end

  // Scoreboard monitor: compare on each dne rise, otherwise p must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (dne && !dne_prev) begin
        if (sb_p.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic [63:0] ep;
          int el;
          ep = sb_p.pop_front();
          el = sb_lat.pop_front();
          check("product", p, ep);
          check("busy_edges", 64'(lat_cnt), 64'(el));
          last_p = ep;
        end
      end else begin
        check("p_hold", p, last_p);
      end
    end
    dne_prev = dne;
  end

  task automatic run_op(input bit s, input logic [31:0] x, input logic [31:0] y,
                        input int stall_at, input int stall_len, input int pulse_at);
    int n;
    int lat;
    lat = ref_lat(s, x);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    sgn = s;
    a = x;
    b = y;
    start = 1'b1;
    sb_p.push_back(ref_prod(s, x, y));
    sb_lat.push_back(lat);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sgn = $urandom_range(0, 1);
    n = 0;
    while (!dne && n < 200) begin
      if (stall_len > 0 && n == stall_at) ena = 1'b0;
      if (n == stall_at + stall_len) ena = 1'b1;
      start = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    ena = 1'b1;
    start = 1'b0;
    if (!dne) check("done_timeout", 64'd1, 64'd0);
    else check("latency", 64'(n), 64'(lat + stall_len));
  endtask

  task automatic run8(input bit s, input logic [7:0] x, input logic [7:0] y);
    int n;
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic [15:0] ep;
    sx = $signed(x);
    sy = $signed(y);
    ep = s ? 16'(sx * sy) : {8'd0, x} * {8'd0, y};
    sgn8 = s;
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!dne8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w8_latency", 64'(n), 64'd10);
    check("w8_product", {48'd0, p8}, {48'd0, ep});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_p = 64'd0;
    lat_cnt = 0;
    dne_prev = 1'b0;
    rst = 1'b1;
    ena = 1'b1;
    start = 1'b0;
    sgn = 1'b0;
    a = 32'd0;
    b = 32'd0;
    ena8 = 1'b1;
    start8 = 1'b0;
    sgn8 = 1'b0;
    a8 = 8'd0;
    b8 = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_p", p, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_dne", {63'd0, dne}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd7, 32'd6, 0, 0, -1);
    check("tp_7x6", p, 64'h2A);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 0, 0, -1);
    check("tp_m3x5", p, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, -1);
    check("tp_umax", p, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0, -1);
    check("tp_smin", p, 64'h4000_0000_0000_0000);
    run_op(1'b1, 32'd0, 32'hFFFF_FFFB, 0, 0, -1);
    check("tp_negzero", p, 64'd0);
    run_op(1'b1, 32'd2, 32'd3, 0, 0, -1);
    check("tp_b2b", p, 64'd6);

    // Long op with start pulses while busy, then with a 3-cycle ena stall.
    run_op(1'b0, 32'hF000_0001, 32'd12345, -1, 0, 4);
    run_op(1'b1, 32'h9000_0001, 32'h8765_4321, 6, 3, 2);

    for (int i = 0; i < 40; i++) begin
      bit s;
      int sh;
      int lat;
      int st_at;
      int st_len;
      int pl;
      logic [31:0] x;
      logic [31:0] y;
      s = $urandom_range(0, 1);
      sh = $urandom_range(0, 32);
      x = (sh == 32) ? 32'd0 : ($urandom >> sh);
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'h8000_0000;
      lat = ref_lat(s, x);
      st_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      st_at = $urandom_range(0, lat - 1);
      pl = ($urandom_range(0, 1) == 0) ? $urandom_range(1, lat - 1) : -1;
      run_op(s, x, y, st_at, st_len, pl);
    end

    // Reset mid-run aborts immediately; next op completes normally.
    run_op(1'b0, 32'd5, 32'd7, 0, 0, -1);
    sgn = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    last_p = 64'd0;
    sb_p.delete();
    sb_lat.delete();
    #1;
    check("abort_p", p, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_dne", {63'd0, dne}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FFF0, 32'd100, 0, 0, -1);
    check("after_abort", p, 64'hFFFF_FFFF_FFFF_F9C0);

    run8(1'b0, 8'd1, 8'd200);
    run8(1'b1, 8'h80, 8'h80);
    for (int i = 0; i < 6; i++) begin
      run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_p.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
